alarm_keypad_entry: RTL



---
 rtl/alarm_keypad_entry_if.sv | 36 +++
 rtl/alarm_keypad_entry.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alarm_keypad_entry_if.sv
// -----------------------------------------------------------------------------
// alarm_keypad_entry_if
//   Bundle between the raw keypad buttons and the alarm core's k4..k0 inputs.
//
//   key_raw   [4:0]  raw active-high buttons, asynchronous to the system clock
//   k         [4:0]  accepted key, one-hot or zero ({k4,k3,k2,k1,k0})
//   key_valid        one-cycle pulse when k takes a newly accepted key
//   key_err          one-cycle pulse when a multi-key press is rejected
//   busy             high whenever the entry FSM is not idle
//
//   master : keypad / environment side (drives key_raw)
//   slave  : the entry block (drives the accepted key and status)
// -----------------------------------------------------------------------------
interface alarm_keypad_entry_if;
  logic [4:0] key_raw;
  logic [4:0] k;
  logic       key_valid;
  logic       key_err;
  logic       busy;

  modport master (
    output key_raw,
    input  k,
    input  key_valid,
    input  key_err,
    input  busy
  );

  modport slave (
    input  key_raw,
    output k,
    output key_valid,
    output key_err,
    output busy
  );
endinterface

// File: rtl/alarm_keypad_entry.sv
// -----------------------------------------------------------------------------
// alarm_keypad_entry
//   Keypad front-end for the alarm core. Synchronises and debounces five raw
//   push-button lines, accepts only single-key presses and holds the accepted
//   key as a one-hot vector on k until a release timeout expires.
//
//   Parameters
//     DEBOUNCE : consecutive differing cycles before a debounced bit flips (>=1)
//     HOLD     : cycles k stays valid after all keys are released (>=1)
//
//   Ports
//     clk    : system clock
//     rst_n  : synchronous, active-low reset
//     kp     : keypad bundle (slave side), see alarm_keypad_entry_if
// -----------------------------------------------------------------------------
module alarm_keypad_entry #(
  parameter int DEBOUNCE = 4,
  parameter int HOLD     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alarm_keypad_entry_if.slave   kp
);

  localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HOLD    = 2'd2,
    ST_REJECT  = 2'd3
  } state_t;

  // True when exactly one bit of the vector is set.
  function automatic logic is_onehot(input logic [4:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'b00, v[i]};
    end
    return (n == 3'd1);
  endfunction

  // True when two or more bits of the vector are set.
  function automatic logic is_multi(input logic [4:0] v);
    return (v != 5'b00000) && !is_onehot(v);
  endfunction

  logic [4:0]    sync1_r;
  logic [4:0]    ks_r;
  logic [4:0]    db_r;
  logic [CW-1:0] cnt_r [5];

  state_t        state_r, state_s;
  logic [4:0]    k_r, k_s;
  logic [HW-1:0] hold_r, hold_s;
  logic          valid_r, valid_s;
  logic          err_r, err_s;
  logic          busy_r;

  logic          db_onehot_s;
  logic          db_multi_s;

  // Two-flop synchroniser on the asynchronous button lines.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 5'b00000;
      ks_r    <= 5'b00000;
    end else begin
      sync1_r <= kp.key_raw;
      ks_r    <= sync1_r;
    end
  end

  // Per-bit debounce: a bit flips only after DEBOUNCE consecutive differing
  // cycles; any agreeing cycle restarts the count, so short glitches vanish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_r <= 5'b00000;
      for (int i = 0; i < 5; i++) begin
        cnt_r[i] <= {CW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (ks_r[i] == db_r[i]) begin
          cnt_r[i] <= {CW{1'b0}};
        end else if (cnt_r[i] == DB_LAST) begin
          db_r[i]  <= ks_r[i];
          cnt_r[i] <= {CW{1'b0}};
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

  // Classify the debounced vector for the FSM.
  always_comb begin
    db_onehot_s = is_onehot(db_r);
    db_multi_s  = is_multi(db_r);
  end

  // Entry FSM next-state and output decode.
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    hold_s  = hold_r;
    valid_s = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (db_onehot_s) begin
          k_s     = db_r;
          valid_s = 1'b1;
          state_s = ST_PRESSED;
        end else if (db_multi_s) begin
          k_s     = 5'b00000;
          err_s   = 1'b1;
          state_s = ST_REJECT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        if (db_r == 5'b00000) begin
          hold_s  = HOLD_LOAD;
          state_s = ST_HOLD;
        end else if (db_r != k_r) begin
          // Second key added or key swapped without a release.
          k_s     = 5'b00000;
          err_s   = 1'b1;
          state_s = ST_REJECT;
        end else begin
          state_s = ST_PRESSED;
        end
      end
      ST_HOLD: begin
        if (db_onehot_s) begin
          // Same key again still counts as a fresh press; k never passes 0.
          k_s     = db_r;
          valid_s = 1'b1;
          state_s = ST_PRESSED;
        end else if (db_multi_s) begin
          k_s     = 5'b00000;
          err_s   = 1'b1;
          state_s = ST_REJECT;
        end else if (hold_r == {HW{1'b0}}) begin
          k_s     = 5'b00000;
          state_s = ST_IDLE;
        end else begin
          hold_s  = hold_r - HW'(1);
        end
      end
      ST_REJECT: begin
        k_s = 5'b00000;
        if (db_r == 5'b00000) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_REJECT;
        end
      end
      default: begin
        k_s     = 5'b00000;
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs; busy tracks the state it is loaded with.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      k_r     <= 5'b00000;
      hold_r  <= {HW{1'b0}};
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      hold_r  <= hold_s;
      valid_r <= valid_s;
      err_r   <= err_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  assign kp.k         = k_r;
  assign kp.key_valid = valid_r;
  assign kp.key_err   = err_r;
  assign kp.busy      = busy_r;

endmodule
